// File: rtl/fadd_share_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit float adder among NREQ requesters,
// with in-order tag routing of sums and a pause/drain FSM. Optional stats: FADD_ARB_STATS_EN.
module fadd_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    input  logic [7:0]           add_res,
    output logic [NREQ-1:0]      resp_valid,
    output logic [7:0]           resp_data,
    input  logic                 pause,
    output logic                 idle,
    output logic [16*NREQ-1:0]   grant_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_idle;
    logic [PW-1:0]   r_ptr;
    logic [ADD_LAT:0] r_tagV;
    logic [PW-1:0]   r_tagId [ADD_LAT+1];
    logic [7:0]      r_addA;
    logic [7:0]      r_addB;
    logic [7:0]      r_respData;
    logic [NREQ-1:0] r_respValid;

    logic            w_hit;
    logic [PW-1:0]   w_gid;
    logic            w_issue;
    logic [NREQ-1:0] w_onehot;

    // Search starts just after the last winner so every requester gets its turn.
    always_comb begin
        w_hit = 1'b0;
        w_gid = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_hit && req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_hit = 1'b1;
                w_gid = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // Grant is masked by rst_n so req_ready drops the moment reset asserts.
    assign w_issue   = rst_n && (r_state == ST_RUN) && !pause && w_hit;
    assign w_onehot  = NREQ'(1) << w_gid;
    assign req_ready = w_issue ? w_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= PW'(NREQ - 1);
            r_addA      <= 8'h00;
            r_addB      <= 8'h00;
            r_tagV      <= '0;
            for (int s = 0; s <= ADD_LAT; s++) begin
                r_tagId[s] <= '0;
            end
            r_respValid <= '0;
            r_respData  <= 8'h00;
        end else begin
            if (w_issue) begin
                r_ptr  <= w_gid;
                r_addA <= req_a[8*w_gid +: 8];
                r_addB <= req_b[8*w_gid +: 8];
            end
            r_tagV[0]  <= w_issue;
            r_tagId[0] <= w_gid;
            for (int s = 1; s <= ADD_LAT; s++) begin
                r_tagV[s]  <= r_tagV[s-1];
                r_tagId[s] <= r_tagId[s-1];
            end
            // The tail tag lines up with the adder result for the same operation.
            if (r_tagV[ADD_LAT]) begin
                r_respData  <= add_res;
                r_respValid <= NREQ'(1) << r_tagId[ADD_LAT];
            end else begin
                r_respValid <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_idle  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_idle <= 1'b0;
                    if (pause) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!pause) begin
                        r_state <= ST_RUN;
                        r_idle  <= 1'b0;
                    end else if (r_tagV == '0) begin
                        r_state <= ST_PAUSED;
                        r_idle  <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        r_state <= ST_RUN;
                        r_idle  <= 1'b0;
                    end else begin
                        r_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_idle  <= 1'b0;
                end
            endcase
        end
    end

    assign add_a      = r_addA;
    assign add_b      = r_addB;
    assign resp_valid = r_respValid;
    assign resp_data  = r_respData;
    assign idle       = r_idle;

`ifdef FADD_ARB_STATS_EN
    logic [15:0] r_grantCnt [NREQ];

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_grantCnt[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_issue && (w_gid == PW'(i)) && (r_grantCnt[i] != 16'hFFFF)) begin
                    r_grantCnt[i] <= r_grantCnt[i] + 16'h0001;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[16*i +: 16] = r_grantCnt[i];
        end
    end
`else
    assign grant_cnt = '0;
`endif

endmodule
